// File: rtl/bit_serializer.sv
// Byte-to-bit serializer: small byte FIFO feeding a shifter that emits one bit per clock.
// Optional even-parity cycle after each byte when SER_PARITY_EN is defined.
module bit_serializer #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MSB_FIRST = 1,
  parameter logic        IDLE_BIT  = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               din,
  input  logic                     din_vld,
  output logic                     din_rdy,
  output logic                     num_o,
  output logic                     bit_vld,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IDX_W  = 4;

  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
  localparam logic [IDX_W-1:0] IDX_DONE  = IDX_W'(BYTE_W);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1
`ifdef SER_PARITY_EN
    ,ST_PARITY = 2'd2
`endif
  } state_e;

  state_e             state_q, state_d;
  logic [BYTE_W-1:0]  mem_q [DEPTH];
  logic [BYTE_W-1:0]  mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [BYTE_W-1:0]  shreg_q, shreg_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               num_q, num_d;
  logic               bit_vld_q, bit_vld_d;

  logic               full_c;
  logic               lvl_nz_c;
  logic               push_c;
  logic               pop_c;
  logic               byte_done_c;
  logic [BYTE_W-1:0]  rd_byte_c;

  // Bit k of a byte in transmit order.
  function automatic logic send_bit(input logic [BYTE_W-1:0] b, input logic [2:0] k);
    logic r;
    if (MSB_FIRST != 0) begin
      r = b[3'd7 - k];
    end else begin
      r = b[k];
    end
    return r;
  endfunction

  assign full_c      = (level_q == LVL_FULL);
  assign lvl_nz_c    = (level_q != '0);
  assign push_c      = din_vld && !full_c;
  assign byte_done_c = (idx_q == IDX_DONE);
  assign rd_byte_c   = mem_q[rd_ptr_q];

  assign din_rdy = !full_c;
  assign num_o   = num_q;
  assign bit_vld = bit_vld_q;
  assign level   = level_q;
  assign busy    = (state_q != ST_IDLE) || lvl_nz_c;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      shreg_q   <= '0;
      idx_q     <= '0;
      num_q     <= IDLE_BIT;
      bit_vld_q <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      shreg_q   <= shreg_d;
      idx_q     <= idx_d;
      num_q     <= num_d;
      bit_vld_q <= bit_vld_d;
      mem_q     <= mem_d;
    end
  end

  // Next state and pop decision; pops look only at the registered level.
  always_comb begin
    state_d = state_q;
    pop_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (lvl_nz_c) begin
          pop_c   = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (byte_done_c) begin
`ifdef SER_PARITY_EN
          state_d = ST_PARITY;
`else
          pop_c   = lvl_nz_c;
          state_d = lvl_nz_c ? ST_SHIFT : ST_IDLE;
`endif
        end
      end
`ifdef SER_PARITY_EN
      ST_PARITY: begin
        pop_c   = lvl_nz_c;
        state_d = lvl_nz_c ? ST_SHIFT : ST_IDLE;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Serial output, shift register and bit index.
  always_comb begin
    shreg_d   = shreg_q;
    idx_d     = idx_q;
    num_d     = IDLE_BIT;
    bit_vld_d = 1'b0;
    if (pop_c) begin
      shreg_d   = rd_byte_c;
      num_d     = send_bit(rd_byte_c, 3'd0);
      bit_vld_d = 1'b1;
      idx_d     = IDX_W'(1);
    end else if (state_q == ST_SHIFT && !byte_done_c) begin
      num_d     = send_bit(shreg_q, idx_q[2:0]);
      bit_vld_d = 1'b1;
      idx_d     = idx_q + IDX_W'(1);
    end
`ifdef SER_PARITY_EN
    else if (state_q == ST_SHIFT) begin
      num_d     = ^shreg_q;
      bit_vld_d = 1'b1;
    end
`endif
    else begin
      idx_d = '0;
    end
  end

  // FIFO pointers, storage and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_c) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_c, pop_c})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: one MSB-first and one LSB-first instance share stimulus.
// Expected bits include the parity bit when SER_PARITY_EN is defined.
module tb_bit_serializer;

  localparam int unsigned DEPTH = 4;
`ifdef SER_PARITY_EN
  localparam int BPB = 9;
`else
  localparam int BPB = 8;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       din_vld = 1'b0;

  logic       rdy_m, num_m, vld_m, busy_m;
  logic       rdy_l, num_l, vld_l, busy_l;
  logic [2:0] level_m, level_l;

  bit   exp_m[$];
  bit   exp_l[$];
  int   pushes = 0;
  int   pops = 0;
  int   cnt = 0;
  int   lvl_prev = 0;
  int   checks = 0;
  int   errors = 0;
  bit   timeout_flag = 1'b0;
  bit   timeout_seen = 1'b0;

  always #5 clk = ~clk;

  bit_serializer #(.DEPTH(DEPTH), .MSB_FIRST(1), .IDLE_BIT(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .din_rdy(rdy_m),
    .num_o(num_m), .bit_vld(vld_m), .busy(busy_m), .level(level_m)
  );

  bit_serializer #(.DEPTH(DEPTH), .MSB_FIRST(0), .IDLE_BIT(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .din_rdy(rdy_l),
    .num_o(num_l), .bit_vld(vld_l), .busy(busy_l), .level(level_l)
  );

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
    end
  endtask

  // Recorder: every accepted byte becomes its expected bit sequence.
  initial forever begin
    logic [7:0] b;
    @(posedge clk or posedge rst);
    if (rst) begin
      exp_m.delete();
      exp_l.delete();
      pushes = 0;
    end else if (din_vld && rdy_m) begin
      b = din;
      for (int k = 0; k < 8; k++) begin
        exp_m.push_back(b[7-k]);
        exp_l.push_back(b[k]);
      end
      if (BPB == 9) begin
        exp_m.push_back(^b);
        exp_l.push_back(^b);
      end
      pushes++;
    end
  end

  // Monitor: derives valid/level timing from occupancy and compares outputs.
  initial forever begin
    bit vld_e;
    int lvl_e;
    bit em, el;
    @(negedge clk);
    if (timeout_flag && !timeout_seen) begin
      timeout_seen = 1'b1;
      chk("timeout", 1, 0);
    end
    if (rst) begin
      pops = 0;
      cnt = 0;
      lvl_prev = 0;
      chk("rst_vld", {vld_m, vld_l}, 0);
      chk("rst_num", {num_m, num_l}, 3);
      chk("rst_level", {level_m, level_l}, 0);
      chk("rst_rdy", {rdy_m, rdy_l}, 3);
      chk("rst_busy", {busy_m, busy_l}, 0);
    end else begin
      vld_e = (cnt != 0) || (lvl_prev != 0);
      if (vld_e && cnt == 0) pops++;
      lvl_e = pushes - pops;
      chk("bit_vld_msb", vld_m, vld_e);
      chk("bit_vld_lsb", vld_l, vld_e);
      if (vld_e) begin
        if (exp_m.size() == 0) begin
          chk("queue_underflow", 0, 1);
        end else begin
          em = exp_m.pop_front();
          el = exp_l.pop_front();
          chk("num_msb", num_m, em);
          chk("num_lsb", num_l, el);
        end
        cnt = (cnt + 1 == BPB) ? 0 : cnt + 1;
      end else begin
        chk("idle_num", {num_m, num_l}, 3);
      end
      chk("level_msb", level_m, lvl_e);
      chk("level_lsb", level_l, lvl_e);
      chk("din_rdy", {rdy_m, rdy_l}, (lvl_e != int'(DEPTH)) ? 3 : 0);
      chk("busy", {busy_m, busy_l}, (vld_e || lvl_e != 0) ? 3 : 0);
      lvl_prev = lvl_e;
    end
  end

  // Offer a byte and hold it until accepted; returns just after the accepting edge.
  task automatic send(input logic [7:0] b);
    bit acc;
    int n;
    din = b;
    din_vld = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = rdy_m;
      @(posedge clk);
      n++;
    end
    if (!acc) timeout_flag = 1'b1;
    #1;
  endtask

  task automatic wait_idle();
    int n;
    din_vld = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy_m || exp_m.size() != 0) && n < 300);
    if (n >= 300) timeout_flag = 1'b1;
  endtask

  initial begin
    int nb;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    send(8'hA5);
    wait_idle();

    send(8'h5A); send(8'h0F); send(8'hF0); send(8'h33);
    wait_idle();

    // Six bytes offered continuously to fill the FIFO while shifting.
    for (int i = 0; i < 6; i++) send(8'hC1 + 8'(i * 7));
    wait_idle();

    // Reset in the middle of a byte, then a clean byte afterwards.
    send(8'hFF);
    din_vld = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    send(8'h00);
    wait_idle();

    send(8'h07); send(8'h03);
    wait_idle();
    send(8'h01);
    wait_idle();

    for (int r = 0; r < 20; r++) begin
      nb = $urandom_range(1, 6);
      for (int j = 0; j < nb; j++) send(8'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        din_vld = 1'b0;
        repeat ($urandom_range(1, 12)) @(posedge clk);
        #1;
      end
    end
    wait_idle();

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Byte-to-bit serializer that sits directly upstream of the serial pattern-detect counter and drives its one-bit `num_i` stream. It accepts bytes over a valid/ready handshake, buffers them in a small FIFO, and shifts each byte out one bit per clock. Consecutive bytes are sent back-to-back with no gap. When no data is available it holds a defined idle level.

## Interface
- `DEPTH`, 4 — FIFO depth in bytes; power of two, ≥2.
- `MSB_FIRST`, 1 — 1: bit 7 is sent first; 0: bit 0 is sent first.
- `IDLE_BIT`, 1'b1 — level driven on `num_o` while no bit is valid.
- `clk`  in  1  — single clock; all logic on rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `din`  in  8  — byte to serialize.
- `din_vld`  in  1  — `din` valid.
- `din_rdy`  out  1  — FIFO can accept; combinational, equals `!full`.
- `num_o`  out  1  — registered serial bit; connects to the detector's `num_i`.
- `bit_vld`  out  1  — registered; `num_o` carries a data or parity bit this cycle.
- `busy`  out  1  — combinational; `state != IDLE || level != 0`.
- `level`  out  $clog2(DEPTH)+1  — registered FIFO occupancy, 0..DEPTH.

## Operation
- Push occurs when `din_vld && din_rdy` at a rising edge. `din` must stay stable while `din_vld=1 && din_rdy=0`.
- The FIFO uses wrapping read/write pointers of width $clog2(DEPTH) plus an occupancy counter. `full` is `level==DEPTH`.
- A push and a pop in the same edge leave `level` unchanged.
- At `level==DEPTH`, `din_rdy=0` even if a pop happens on the same edge; no same-cycle pass-through.
- A pop uses only registered `level`. A byte pushed at edge N can be popped no earlier than edge N+1.
- States: IDLE, SHIFT, PARITY. PARITY exists only when the macro is defined.
- **IDLE**
  - If `level != 0`: pop a byte into `shreg` and drive its first bit, `bit_vld<=1`, `idx<=1`, go to SHIFT.
  - Otherwise hold `num_o=IDLE_BIT`, `bit_vld=0`.
- **SHIFT**, each edge:
  - If `idx<8`: drive bit `idx` in send order, then `idx<=idx+1`.
  - If `idx==8` (byte complete):
    - With parity: drive the parity bit, go to PARITY.
    - Otherwise apply the **next-byte decision**.
- **PARITY**, next edge: apply the next-byte decision.
- **Next-byte decision**
  - If `level != 0`: pop, drive the first bit, `idx<=1`, stay in or return to SHIFT. No gap between bytes.
  - Otherwise: `num_o<=IDLE_BIT`, `bit_vld<=0`, go to IDLE.
- Send order:
  - `MSB_FIRST=1`: bit index k maps to `shreg[7-k]`.
  - `MSB_FIRST=0`: bit index k maps to `shreg[k]`.
- Once a byte is popped it is always sent completely. No abort exists except reset.
- **Reset** (asynchronous, at any time, including mid-byte):
  - State IDLE, FIFO emptied, pointers 0, `level=0`, `idx=0`, `shreg=0`.
  - `num_o=IDLE_BIT`, `bit_vld=0`; therefore `busy=0` and `din_rdy=1`.
  - A partially sent byte is discarded.

## Timing
- Latency: byte accepted at edge N into an empty, idle block → first bit on `num_o` after edge N+1, `bit_vld=1`.
- Throughput: one bit per cycle.
  - Without parity: 8 cycles per byte.
  - With parity: 9 cycles per byte.
- `level` is updated at the same edge as the push or pop.
- `bit_vld` falls at the edge after the last bit of the last buffered byte.

## Configuration
- Macro: `SER_PARITY_EN`.
- **Defined:** after bit 7 of each byte, one extra cycle drives the even-parity bit `^byte` with `bit_vld=1`. PARITY state is present; 9 cycles per byte.
- **Undefined:** no parity cycle and no PARITY state; 8 cycles per byte.

## Test plan
1. Reset, then push 8'hA5 (MSB_FIRST=1) → starting one cycle after acceptance, `num_o`=1,0,1,0,0,1,0,1 with `bit_vld=1` for 8 cycles. Then `num_o=1`, `bit_vld=0`, `busy=0`.
2. Push 8'h5A, 8'h0F, 8'hF0, 8'h33 back-to-back (MSB_FIRST=1) → 32 contiguous valid bits in order with no gap; `level` peaks and returns to 0.
3. Hold `din_vld=1` with 6 distinct bytes while the shifter runs, DEPTH=4:
   - `din_rdy` drops when `level==4` and rises after the next pop.
   - All 6 bytes are sent in order; none are lost or duplicated.
4. Push 8'hFF, assert `rst` asynchronously after 3 bits → immediately `bit_vld=0`, `num_o=1`, `level=0`, `din_rdy=1`. Push 8'h00 after release → exactly 8 zero bits follow.
5. With `SER_PARITY_EN`:
   - Push 8'h07 → 9th bit is 1.
   - Push 8'h03 → 9th bit is 0.
   - Bytes are spaced 9 cycles apart.
6. MSB_FIRST=0, push 8'h01 → `num_o`=1,0,0,0,0,0,0,0.
